// File: rtl/mem_port_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like memory port between instruction fetch and data cache.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise the data side always wins.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [1:0]            inst_size,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0] inst_wdata,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,

    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_owner;
    logic   contention_pick;
    logic   in_addr;
    logic   addr_hs;
    logic   data_hs;

    // On simultaneous requests, contention_pick selects the data side when 1.
`ifdef ARB_ROUND_ROBIN_EN
    assign contention_pick = ~last_owner;
`else
    logic last_owner_unused;
    assign last_owner_unused = last_owner;
    assign contention_pick   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        owner <= data_req && (!inst_req || contention_pick);
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_addr_ok) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (mem_data_ok) begin
                        last_owner <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_addr = (state == ADDR);
    assign addr_hs = in_addr && mem_addr_ok;
    assign data_hs = (state == DATA) && mem_data_ok;

    assign mem_req = in_addr;

    // Request fields follow the owner's live inputs, and are forced to zero outside ADDR.
    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_addr) begin
            if (owner) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign inst_addr_ok = addr_hs && !owner;
    assign data_addr_ok = addr_hs && owner;
    assign inst_data_ok = data_hs && !owner;
    assign data_data_ok = data_hs && owner;

    assign inst_rdata = inst_data_ok ? mem_rdata : '0;
    assign data_rdata = data_data_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: vector table plus stall, contention and reset sequences.
module tb_mem_port_arbiter;

    localparam logic [31:0] I_ADDR  = 32'hBFC0_0000;
    localparam logic [31:0] I_WDATA = 32'h1234_5678;
    localparam logic [31:0] D_ADDR  = 32'h8000_1003;
    localparam logic [31:0] D_WDATA = 32'h0000_00AB;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int compared;
    int mismatched;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ireq;
        logic         dreq;
        logic         aok;
        logic         dok;
        logic [31:0]  rdata;
        logic [135:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [135:0] mkExp(input logic mreq, input logic mwr, input logic [1:0] msize,
                                           input logic [31:0] maddr, input logic [31:0] mwdata,
                                           input logic iao, input logic ido, input logic dao, input logic ddo,
                                           input logic [31:0] irdata, input logic [31:0] drdata);
        return {mreq, mwr, msize, maddr, mwdata, iao, ido, dao, ddo, irdata, drdata};
    endfunction

    function automatic logic [135:0] gatherOutputs();
        return {mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
                inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, inst_rdata, data_rdata};
    endfunction

    function automatic logic [135:0] addrPhaseExp(input logic side);
        return side ? mkExp(1'b1, 1'b1, 2'b00, D_ADDR, D_WDATA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0)
                    : mkExp(1'b1, 1'b0, 2'b10, I_ADDR, I_WDATA, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ireq, input logic dreq, input logic aok,
                                 input logic dok, input logic [31:0] rdata);
        inst_req    = ireq;
        data_req    = dreq;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rdata;
        #3;
    endtask

    task automatic checkOutput(input string name, input logic [135:0] exp);
        logic [135:0] act;
        act = gatherOutputs();
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checkOutput("reset_state", '0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
    endtask

    initial begin
        logic side;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        inst_wr    = 1'b0;  inst_size = 2'b10; inst_addr = I_ADDR; inst_wdata = I_WDATA;
        data_wr    = 1'b1;  data_size = 2'b00; data_addr = D_ADDR; data_wdata = D_WDATA;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        doReset();

        // Inst read with immediate accept, then data byte write, with spurious handshakes in IDLE.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, '0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, addrPhaseExp(1'b0)};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2408_0001,
                    mkExp(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2408_0001, 32'h0)};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, '0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, '0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, addrPhaseExp(1'b1)};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0055,
                    mkExp(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0055)};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, '0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
            cycle();
        end

        // Both sides request continuously for four transactions from a fresh reset.
        doReset();
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
            side = (t % 2 == 0);
`else
            side = 1'b1;
`endif
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            cycle();
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput($sformatf("contend_addr%0d", t), addrPhaseExp(side));
            cycle();
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'(t + 1));
            checkOutput($sformatf("contend_data%0d", t),
                        mkExp(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, !side, 1'b0, side,
                              side ? 32'h0 : 32'(t + 1), side ? 32'(t + 1) : 32'h0));
            cycle();
        end

        // Memory stalls the address phase for five cycles; inst drops req midway without aborting.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k < 2, 1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput($sformatf("stall%0d", k),
                        mkExp(1'b1, 1'b0, 2'b10, I_ADDR, I_WDATA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
            cycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_accept", addrPhaseExp(1'b0));
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077);
        checkOutput("stall_data",
                    mkExp(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0));
        cycle();

        // Reset while in DATA; the late data_ok must not reach either side.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_mid_addr", addrPhaseExp(1'b1));
        cycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0099);
        checkOutput("rst_mid_late_data_ok", '0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_mid_idle", '0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
